// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX/MEM status in, stall/flush enables and perf counters out.
// The pipeline side uses the master modport; hazard_ctrl uses the slave modport.
interface hazard_ctrl_if;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd_addr;
  logic        ex_mem_read_en;
  logic        ex_redirect;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_stall;
  logic        id_ex_flush;
  logic        ex_mem_stall;
  logic        mem_timeout;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
    output ex_rd_addr, ex_mem_read_en, ex_redirect, mem_req, mem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    input  ex_mem_stall, mem_timeout, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
    input  ex_rd_addr, ex_mem_read_en, ex_redirect, mem_req, mem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    output ex_mem_stall, mem_timeout, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencing controller: load-use stall, redirect squash, memory-wait freeze.
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 16
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

  state_t           state_q, state_d;
  logic [FCW-1:0]   flush_q, flush_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             timeout_q, timeout_set;
  logic             mem_wait, load_use;
  logic             pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic             id_ex_stall_c, id_ex_flush_c, ex_mem_stall_c;

  assign mem_wait = hz.mem_req & ~hz.mem_ready;
  assign load_use = hz.ex_mem_read_en & (hz.ex_rd_addr != 5'd0) &
                    ((hz.id_uses_rs1 & (hz.id_rs1_addr == hz.ex_rd_addr)) |
                     (hz.id_uses_rs2 & (hz.id_rs2_addr == hz.ex_rd_addr)));

  always_comb begin
    state_d        = state_q;
    flush_d        = flush_q;
    wait_d         = '0;
    timeout_set    = 1'b0;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    if (mem_wait) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      state_d        = MEM_WAIT;
      wait_d         = (wait_q == WCW'(MEM_TIMEOUT)) ? wait_q : wait_q + 1'b1;
      timeout_set    = (wait_q >= WCW'(MEM_TIMEOUT - 1));
    end else if (hz.ex_redirect) begin
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      flush_d       = FCW'(FLUSH_CYCLES - 1);
      state_d       = (FLUSH_CYCLES > 1) ? REDIRECT : RUN;
    end else begin
      case (state_q)
        REDIRECT: begin
          if_id_flush_c = 1'b1;
          flush_d       = flush_q - 1'b1;
          state_d       = (flush_q == FCW'(1)) ? RUN : REDIRECT;
        end
        // Release cycle of a wait: a frozen redirect sequence resumes next cycle,
        // otherwise the ID/EX pair is live again and may still form a load-use hazard.
        MEM_WAIT: begin
          state_d = (flush_q != '0) ? REDIRECT : RUN;
          if (flush_q == '0 && load_use) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end
        end
        default: begin
          state_d = RUN;
          if (load_use) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      flush_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_q | timeout_set;
    end
  end

  assign hz.pc_stall     = rst_n & pc_stall_c;
  assign hz.if_id_stall  = rst_n & if_id_stall_c;
  assign hz.if_id_flush  = rst_n & if_id_flush_c;
  assign hz.id_ex_stall  = rst_n & id_ex_stall_c;
  assign hz.id_ex_flush  = rst_n & id_ex_flush_c;
  assign hz.ex_mem_stall = rst_n & ex_mem_stall_c;
  assign hz.mem_timeout  = rst_n & (timeout_q | timeout_set);

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_inc;

  assign stall_inc = pc_stall_c & ~hz.ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush_c && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.perf_stall_cnt = stall_cnt_q;
  assign hz.perf_flush_cnt = flush_cnt_q;
`else
  assign hz.perf_stall_cnt = '0;
  assign hz.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the sequencing rules.
module tb_hazard_ctrl;

  localparam int unsigned FC = 2;
  localparam int unsigned MT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: flush cycles still owed after a redirect, current wait run length,
  // sticky timeout, whether the previous cycle was a memory wait, perf counts.
  int          m_owed, m_wait;
  bit          m_timeout, m_prev_mw;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  // Expected outputs / next model state for the current cycle.
  bit e_pc_stall, e_if_id_stall, e_if_id_flush, e_id_ex_stall, e_id_ex_flush, e_ex_mem_stall;
  int n_owed, n_wait;
  bit n_timeout, n_mw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic ld,
                        input logic redir, input logic req, input logic rdy);
    hz.id_rs1_addr    = rs1;
    hz.id_rs2_addr    = rs2;
    hz.id_uses_rs1    = u1;
    hz.id_uses_rs2    = u2;
    hz.ex_rd_addr     = rd;
    hz.ex_mem_read_en = ld;
    hz.ex_redirect    = redir;
    hz.mem_req        = req;
    hz.mem_ready      = rdy;
  endtask

  task automatic model_reset();
    m_owed = 0; m_wait = 0; m_timeout = 0; m_prev_mw = 0;
    m_stall_cnt = '0; m_flush_cnt = '0;
  endtask

  task automatic model_eval();
    bit lu;
    n_mw = hz.mem_req && !hz.mem_ready;
    lu = hz.ex_mem_read_en && (hz.ex_rd_addr != 0) &&
         ((hz.id_uses_rs1 && hz.id_rs1_addr == hz.ex_rd_addr) ||
          (hz.id_uses_rs2 && hz.id_rs2_addr == hz.ex_rd_addr));
    {e_pc_stall, e_if_id_stall, e_if_id_flush, e_id_ex_stall, e_id_ex_flush, e_ex_mem_stall} = '0;
    n_owed = m_owed; n_wait = 0; n_timeout = m_timeout;
    if (n_mw) begin
      {e_pc_stall, e_if_id_stall, e_id_ex_stall, e_ex_mem_stall} = 4'hF;
      n_wait = m_wait + 1;
      if (n_wait >= MT) n_timeout = 1;
    end else if (hz.ex_redirect) begin
      e_if_id_flush = 1; e_id_ex_flush = 1;
      n_owed = FC - 1;
    end else if (m_owed > 0) begin
      if (!m_prev_mw) begin
        e_if_id_flush = 1;
        n_owed = m_owed - 1;
      end
    end else if (lu) begin
      e_pc_stall = 1; e_if_id_stall = 1; e_id_ex_flush = 1;
    end
  endtask

  task automatic model_commit();
    if (e_pc_stall && !hz.ex_redirect && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (e_if_id_flush && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    m_owed = n_owed; m_wait = n_wait; m_timeout = n_timeout; m_prev_mw = n_mw;
  endtask

  task automatic check_outputs(input bit p, input bit s1, input bit f1, input bit s2,
                               input bit f2, input bit s3, input bit to,
                               input logic [31:0] sc, input logic [31:0] fc);
    check("pc_stall",     32'(hz.pc_stall),     32'(p));
    check("if_id_stall",  32'(hz.if_id_stall),  32'(s1));
    check("if_id_flush",  32'(hz.if_id_flush),  32'(f1));
    check("id_ex_stall",  32'(hz.id_ex_stall),  32'(s2));
    check("id_ex_flush",  32'(hz.id_ex_flush),  32'(f2));
    check("ex_mem_stall", 32'(hz.ex_mem_stall), 32'(s3));
    check("mem_timeout",  32'(hz.mem_timeout),  32'(to));
`ifdef HAZARD_CTRL_PERF_EN
    check("perf_stall_cnt", hz.perf_stall_cnt, sc);
    check("perf_flush_cnt", hz.perf_flush_cnt, fc);
`else
    check("perf_stall_cnt", hz.perf_stall_cnt, 32'h0);
    check("perf_flush_cnt", hz.perf_flush_cnt, 32'h0);
`endif
  endtask

  // Inputs are applied at the negedge before calling; outputs checked 1ns later.
  task automatic run_cycle();
    #1;
    model_eval();
    check_outputs(e_pc_stall, e_if_id_stall, e_if_id_flush, e_id_ex_stall, e_id_ex_flush,
                  e_ex_mem_stall, n_timeout, m_stall_cnt, m_flush_cnt);
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_cycle();
    end
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check_outputs(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on rs1, then the bubble removes the load from EX.
    set_in(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); run_cycle();
    set_in(5'd5, 5'd7, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0); run_cycle();
    // Load-use on rs2.
    set_in(5'd3, 5'd6, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); run_cycle();
    // x0 load, and rs2 match with rs2 unused.
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); run_cycle();
    set_in(5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); run_cycle();
    // Single-cycle redirect.
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); run_cycle();
    idle(3);
    // Redirect and load-use together.
    set_in(5'd4, 5'd2, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0); run_cycle();
    // Load-use ignored while the squash is in progress.
    set_in(5'd4, 5'd2, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); run_cycle();
    idle(2);
    // Redirect held through a memory wait.
    for (int i = 0; i < 4; i++) begin
      set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); run_cycle();
    end
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1); run_cycle();
    idle(3);
    // Memory wait interrupting a squash sequence.
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); run_cycle();
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); run_cycle();
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); run_cycle();
    idle(3);
    // Reset in the middle of a squash.
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); run_cycle();
    async_reset();
    idle(2);
    // 20-cycle wait crossing the timeout, then release.
    for (int i = 0; i < 20; i++) begin
      set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); run_cycle();
    end
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); run_cycle();
    idle(3);
    // Reset in the middle of a wait clears the sticky timeout.
    for (int i = 0; i < 3; i++) begin
      set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); run_cycle();
    end
    async_reset();
    idle(2);

    // Randomized traffic with small register indices to make hazards frequent.
    for (int i = 0; i < 4000; i++) begin
      logic req, rdy;
      req = ($urandom_range(0, 9) < 3);
      rdy = ($urandom_range(0, 9) < (i % 500 < 100 ? 1 : 5));
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 9) == 0), req, rdy);
      run_cycle();
      if (i % 700 == 699) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
